// File: rtl/ama_riscv_rf_wb_arbiter_if.sv
// Write-back request bundle between the NUM_REQ producers and the RF write-back arbiter.
// Requester i occupies addr bits [5i+4:5i] and data bits [XLEN*i+XLEN-1:XLEN*i].
interface ama_riscv_rf_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [5*NUM_REQ-1:0]    req_addr;
    logic [XLEN*NUM_REQ-1:0] req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/ama_riscv_rf_wb_arbiter.sv
// Round-robin write-back arbiter for the RV32I register file write port, with a registered
// output stage. Define RF_ARB_SCOREBOARD_EN to add the pending-write scoreboard and RAW hazard flags.
module ama_riscv_rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ama_riscv_rf_wb_arbiter_if.slave req,
    output logic                 rf_we,
    output logic [4:0]           rf_addr_d,
    output logic [XLEN-1:0]      rf_data_d,
    input  logic                 rsv_valid,
    input  logic [4:0]           rsv_addr,
    input  logic [4:0]           rd_addr_a,
    input  logic [4:0]           rd_addr_b,
    output logic                 hazard_a,
    output logic                 hazard_b
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_valid;
    logic [4:0]       grant_addr;
    logic [XLEN-1:0]  grant_data;
    logic             wr_nz;

    // Search ptr, ptr+1, ... modulo NUM_REQ; the first valid requester wins.
    always_comb begin : rr_select
        int unsigned idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_valid && req.req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin : grant_mux
        req.req_ready = '0;
        grant_addr    = '0;
        grant_data    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && grant_idx == PTR_W'(i)) begin
                req.req_ready[i] = 1'b1;
                grant_addr       = req.req_addr[5*i +: 5];
                grant_data       = req.req_data[XLEN*i +: XLEN];
            end
        end
    end

    // A grant is only issued to a valid requester, so grant_valid is the handshake.
    assign wr_nz = grant_valid && (grant_addr != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            rf_we     <= 1'b0;
            rf_addr_d <= '0;
            rf_data_d <= '0;
        end else begin
            rf_we <= wr_nz;
            if (grant_valid) begin
                ptr       <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                rf_addr_d <= grant_addr;
                rf_data_d <= grant_data;
            end
        end
    end

`ifdef RF_ARB_SCOREBOARD_EN
    logic [31:1] busy;
    logic [31:1] busy_nxt;

    // Clear first, then set, so a same-cycle reserve of the retiring index keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_nz) busy_nxt[grant_addr] = 1'b0;
        if (rsv_valid && rsv_addr != 5'd0) busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    // The output-stage term covers the cycle between handshake and the actual RF write.
    assign hazard_a = (rd_addr_a != 5'd0) &&
                      (busy[rd_addr_a] || (rf_we && rf_addr_d == rd_addr_a));
    assign hazard_b = (rd_addr_b != 5'd0) &&
                      (busy[rd_addr_b] || (rf_we && rf_addr_d == rd_addr_b));
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{rsv_valid, rsv_addr, rd_addr_a, rd_addr_b};
    assign hazard_a = 1'b0;
    assign hazard_b = 1'b0;
`endif

endmodule

// File: tb/tb_ama_riscv_rf_wb_arbiter.sv
// Randomized self-checking bench for ama_riscv_rf_wb_arbiter against a behavioural model.
// Honours RF_ARB_SCOREBOARD_EN the same way as the design.
module tb_ama_riscv_rf_wb_arbiter;
    localparam int N = 3;
    localparam int W = 32;

    logic       clk;
    logic       rst_n;
    logic       rf_we;
    logic [4:0] rf_addr_d;
    logic [W-1:0] rf_data_d;
    logic       rsv_valid;
    logic [4:0] rsv_addr;
    logic [4:0] rd_addr_a;
    logic [4:0] rd_addr_b;
    logic       hazard_a;
    logic       hazard_b;

    ama_riscv_rf_wb_arbiter_if #(.NUM_REQ(N), .XLEN(W)) req_if ();

    ama_riscv_rf_wb_arbiter #(.NUM_REQ(N), .XLEN(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_if.slave),
        .rf_we     (rf_we),
        .rf_addr_d (rf_addr_d),
        .rf_data_d (rf_data_d),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .hazard_a  (hazard_a),
        .hazard_b  (hazard_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester stimulus
    logic [N-1:0] v;
    logic [4:0]   a_q [N];
    logic [W-1:0] d_q [N];

    // Reference model state
    int          m_ptr;
    bit          m_we;
    bit [4:0]    m_addr;
    bit [W-1:0]  m_data;
    bit [31:0]   m_busy;
    int          last_g;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic m_reset();
        m_ptr  = 0;
        m_we   = 0;
        m_addr = '0;
        m_data = '0;
        m_busy = '0;
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit exp_hazard(input logic [4:0] rd);
`ifdef RF_ARB_SCOREBOARD_EN
        return (rd != 0) && (m_busy[rd] || (m_we && m_addr == rd));
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_if.req_valid[i]        = v[i];
            req_if.req_addr[5*i +: 5]  = a_q[i];
            req_if.req_data[W*i +: W]  = d_q[i];
        end
    endtask

    // One clock: check the combinational outputs, advance the model, check the output stage.
    task automatic step();
        int g;
        drive();
        #1;
        g = exp_grant();
        check("req_ready", 64'(req_if.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        check("hazard_a", 64'(hazard_a), 64'(exp_hazard(rd_addr_a)));
        check("hazard_b", 64'(hazard_b), 64'(exp_hazard(rd_addr_b)));
        @(posedge clk);
        if (g >= 0) begin
            m_we   = (a_q[g] != 0);
            m_addr = a_q[g];
            m_data = d_q[g];
            if (a_q[g] != 0) m_busy[a_q[g]] = 1'b0;
            m_ptr  = (g + 1) % N;
        end else begin
            m_we = 1'b0;
        end
        if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        last_g = g;
        @(negedge clk);
        check("rf_we", 64'(rf_we), 64'(m_we));
        check("rf_addr_d", 64'(rf_addr_d), 64'(m_addr));
        check("rf_data_d", 64'(rf_data_d), 64'(m_data));
    endtask

    initial begin
        rst_n     = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        v         = '1;
        a_q[0] = 5'd1; a_q[1] = 5'd2; a_q[2] = 5'd3;
        d_q[0] = 32'h11; d_q[1] = 32'h22; d_q[2] = 32'h33;
        m_reset();
        last_g = -1;
        drive();
        #1;
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_rf_addr", 64'(rf_addr_d), 64'd0);
        check("rst_rf_data", 64'(rf_data_d), 64'd0);
        check("rst_ready", 64'(req_if.req_ready), 64'b001);
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters valid: grants rotate 0,1,2,0
        repeat (4) step();

        // Single LSU write to x5
        v = 3'b010; a_q[1] = 5'd5; d_q[1] = 32'hDEADBEEF;
        step();
        v = '0;
        step();

        // x0 write completes without rf_we, pointer wraps to 0
        v = 3'b100; a_q[2] = 5'd0; d_q[2] = 32'h1234;
        step();
        v = 3'b101; a_q[0] = 5'd3; a_q[2] = 5'd4;
        step();
        v = 3'b100;
        step();
        v = '0;

        // Reserve x7, retire it through the LSU
        rsv_valid = 1'b1; rsv_addr = 5'd7; rd_addr_a = 5'd7; rd_addr_b = 5'd0;
        step();
        rsv_valid = 1'b0;
        step();
        v = 3'b010; a_q[1] = 5'd7;
        step();
        v = '0;
        step();
        step();
        rd_addr_a = 5'd0; rsv_valid = 1'b1; rsv_addr = 5'd0;
        step();

        // Same-cycle reserve and retire of x9: reserve wins
        rsv_addr = 5'd9; v = 3'b001; a_q[0] = 5'd9; rd_addr_b = 5'd9;
        step();
        rsv_valid = 1'b0; v = '0;
        step();
        step();

        // Asynchronous reset mid-cycle with a pending write and busy entries
        v = 3'b111; a_q[0] = 5'd10; a_q[1] = 5'd11; a_q[2] = 5'd12;
        rsv_valid = 1'b1; rsv_addr = 5'd13; rd_addr_a = 5'd13;
        step();
        step();
        rsv_valid = 1'b0;
        rd_addr_b = rf_addr_d;
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("arst_rf_we", 64'(rf_we), 64'd0);
        check("arst_rf_addr", 64'(rf_addr_d), 64'd0);
        check("arst_rf_data", 64'(rf_data_d), 64'd0);
        check("arst_hazard_a", 64'(hazard_a), 64'd0);
        check("arst_hazard_b", 64'(hazard_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Randomized traffic; requesters hold until granted
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (last_g == i || !v[i]) begin
                    v[i]   = ($urandom_range(0, 99) < 60);
                    a_q[i] = 5'($urandom_range(0, 9));
                    d_q[i] = $urandom;
                end
            end
            rsv_valid = ($urandom_range(0, 99) < 35);
            rsv_addr  = 5'($urandom_range(0, 9));
            rd_addr_a = 5'($urandom_range(0, 9));
            rd_addr_b = 5'($urandom_range(0, 31));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
